// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_counter_bank
//  Description : WIDTH-bit bank of JK flip-flops with up/down/freeze count
//                modes over a programmable modulus, a combinational
//                terminal-count flag and a registered one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock    in   1      rising-edge clock for all state
//    reset_n  in   1      synchronous active-low reset (q <= RESET_VAL)
//    en       in   1      1 = state may change this edge, 0 = hold
//    mode     in   2      00 JK, 01 count up, 10 count down, 11 freeze
//    j        in   WIDTH  per-bit J inputs (JK mode only)
//    k        in   WIDTH  per-bit K inputs (JK mode only)
//    q        out  WIDTH  registered bank state
//    q_bar    out  WIDTH  exact complement of q
//    tc       out  1      terminal count: a wrap happens on the next edge
//    wrap     out  1      one-cycle pulse in the cycle after a count wrap
// ============================================================================
module jk_counter_bank #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0] c_mode_jk   = 2'b00;
    localparam logic [1:0] c_mode_up   = 2'b01;
    localparam logic [1:0] c_mode_down = 2'b10;
    localparam logic [1:0] c_mode_frz  = 2'b11;

    // Highest legal count value and the reset load value, sized to the bank.
    localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero  = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_q;
    logic             w_next_wrap;
    logic [WIDTH-1:0] w_jk_q;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_over;

    // Classic JK characteristic equation, applied bitwise:
    // set where J=1 and q=0, keep where K=0 and q=1 (JK=11 toggles).
    assign w_jk_q    = (j & ~r_q) | (~k & r_q);

    assign w_at_max  = (r_q == c_max);
    assign w_at_zero = (r_q == c_zero);
    // JK mode can leave q above the modulus; count modes resynchronise it
    // without raising wrap.
    assign w_over    = (r_q > c_max);

    always_comb begin
        w_next_q    = r_q;
        w_next_wrap = 1'b0;
        if (en) begin
            case (mode)
                c_mode_jk: begin
                    w_next_q = w_jk_q;
                end
                c_mode_up: begin
                    if (w_at_max) begin
                        w_next_q    = c_zero;
                        w_next_wrap = 1'b1;
                    end else if (w_over) begin
                        w_next_q = c_zero;
                    end else begin
                        w_next_q = r_q + c_one;
                    end
                end
                c_mode_down: begin
                    if (w_at_zero) begin
                        w_next_q    = c_max;
                        w_next_wrap = 1'b1;
                    end else if (w_over) begin
                        w_next_q = c_max;
                    end else begin
                        w_next_q = r_q - c_one;
                    end
                end
                c_mode_frz: begin
                    w_next_q = r_q;
                end
                default: begin
                    w_next_q = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_q    <= c_reset;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_next_q;
            r_wrap <= w_next_wrap;
        end
    end

    assign q     = r_q;
    assign q_bar = ~r_q;
    assign wrap  = r_wrap;
    assign tc    = en & (((mode == c_mode_up)   & w_at_max) |
                         ((mode == c_mode_down) & w_at_zero));

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_counter_bank
//  Description : Self-checking bench for jk_counter_bank. Two instances
//                (4-bit mod 10 reset 0, and 3-bit mod 5 reset 3) share the
//                stimulus; an integer-arithmetic model is compared against
//                both every cycle, plus hand-computed directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_counter_bank;

    logic       clock;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;

    logic [3:0] q1, qb1;
    logic       tc1, w1;
    logic [2:0] q2, qb2;
    logic       tc2, w2;

    int checks = 0;
    int errors = 0;

    // Model state: plain integers per instance.
    int m1q, m2q;
    bit m1w, m2w;
    bit mvalid = 1'b0;

    jk_counter_bank #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut1 (
        .clock(clock), .reset_n(rst_n), .en(en), .mode(mode),
        .j(j), .k(k), .q(q1), .q_bar(qb1), .tc(tc1), .wrap(w1)
    );

    jk_counter_bank #(.WIDTH(3), .MODULUS(5), .RESET_VAL(3)) u_dut2 (
        .clock(clock), .reset_n(rst_n), .en(en), .mode(mode),
        .j(j[2:0]), .k(k[2:0]), .q(q2), .q_bar(qb2), .tc(tc2), .wrap(w2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Next state of one bank, from the behavioural rules on integers.
    function automatic void step(input int w, input int md, input int rv,
                                 inout int mq, inout bit mw);
        int nq;
        mw = 1'b0;
        if (!rst_n) begin
            mq = rv;
            return;
        end
        if (!en || mode == 2'd3) return;
        case (mode)
            2'd0: begin
                nq = 0;
                for (int b = 0; b < w; b++) begin
                    int jb, kb, qbit, nb;
                    jb   = (j >> b) & 1;
                    kb   = (k >> b) & 1;
                    qbit = (mq >> b) & 1;
                    if (jb == 1 && kb == 1) nb = 1 - qbit;
                    else if (jb == 1)       nb = 1;
                    else if (kb == 1)       nb = 0;
                    else                    nb = qbit;
                    nq = nq + (nb << b);
                end
                mq = nq;
            end
            2'd1: begin
                if (mq == md - 1)     begin mq = 0; mw = 1'b1; end
                else if (mq > md - 1) mq = 0;
                else                  mq = mq + 1;
            end
            default: begin
                if (mq == 0)          begin mq = md - 1; mw = 1'b1; end
                else if (mq > md - 1) mq = md - 1;
                else                  mq = mq - 1;
            end
        endcase
    endfunction

    function automatic logic tc_of(input int mq, input int md);
        return en && ((mode == 2'd1 && mq == md - 1) || (mode == 2'd2 && mq == 0));
    endfunction

    always @(posedge clock) begin
        step(4, 10, 0, m1q, m1w);
        step(3, 5, 3, m2q, m2w);
        if (!rst_n) mvalid = 1'b1;
    end

    always @(negedge clock) begin
        if (mvalid) begin
            check("m_q1",    32'(q1),  32'(m1q));
            check("m_qbar1", 32'(qb1), 32'((~m1q) & 15));
            check("m_tc1",   32'(tc1), 32'(tc_of(m1q, 10)));
            check("m_wrap1", 32'(w1),  32'(m1w));
            check("m_q2",    32'(q2),  32'(m2q));
            check("m_qbar2", 32'(qb2), 32'((~m2q) & 7));
            check("m_tc2",   32'(tc2), 32'(tc_of(m2q, 5)));
            check("m_wrap2", 32'(w2),  32'(m2w));
        end
    end

    task automatic set(input logic rn, input logic e, input logic [1:0] m,
                       input logic [3:0] jj, input logic [3:0] kk);
        rst_n = rn; en = e; mode = m; j = jj; k = kk;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exp3 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        // Reset with arbitrary data inputs.
        set(1'b0, 1'b1, 2'b01, 4'hA, 4'h6);
        tick();
        check("rst_q",    32'(q1),  32'h0);
        check("rst_qbar", 32'(qb1), 32'hF);
        check("rst_wrap", 32'(w1),  32'h0);
        check("rst_tc",   32'(tc1), 32'h0);
        check("rst_q2",   32'(q2),  32'h3);

        // JK mode: load 0101, then set/hold/clear/toggle.
        set(1'b1, 1'b1, 2'b00, 4'b0101, 4'b0000);
        tick();
        check("jk_load", 32'(q1), 32'b0101);
        set(1'b1, 1'b1, 2'b00, 4'b1001, 4'b0011);
        tick();
        check("jk_ops", 32'(q1), 32'b1100);

        // Up count from 0 for 12 edges.
        set(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
        tick();
        set(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up_q",    32'(q1),  32'(exp3[i]));
            check("up_tc",   32'(tc1), 32'(exp3[i] == 9));
            check("up_wrap", 32'(w1),  32'(i == 9));
        end

        // Down count from 0: tc, wrap to 9, then 8.
        set(1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        tick();
        set(1'b1, 1'b1, 2'b10, 4'h0, 4'h0);
        check("dn_tc0", 32'(tc1), 32'h1);
        tick();
        check("dn_q9",    32'(q1), 32'd9);
        check("dn_wrap1", 32'(w1), 32'h1);
        tick();
        check("dn_q8",    32'(q1), 32'd8);
        check("dn_wrap0", 32'(w1), 32'h0);

        // Back-to-back wraps: up 8->9->0, then down 0->9.
        set(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        tick();
        tick();
        check("b2b_q0",    32'(q1), 32'd0);
        check("b2b_wrapA", 32'(w1), 32'h1);
        set(1'b1, 1'b1, 2'b10, 4'h0, 4'h0);
        tick();
        check("b2b_q9",    32'(q1), 32'd9);
        check("b2b_wrapB", 32'(w1), 32'h1);

        // Out-of-range recovery: JK drives 13 (from 9), then up -> 0.
        set(1'b1, 1'b1, 2'b00, 4'b1101, 4'b0010);
        tick();
        check("oor_13a", 32'(q1), 32'd13);
        set(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        check("oor_tc_up", 32'(tc1), 32'h0);
        tick();
        check("oor_up_q",    32'(q1), 32'd0);
        check("oor_up_wrap", 32'(w1), 32'h0);
        set(1'b1, 1'b1, 2'b00, 4'b1101, 4'b0010);
        tick();
        check("oor_13b", 32'(q1), 32'd13);
        set(1'b1, 1'b1, 2'b10, 4'h0, 4'h0);
        tick();
        check("oor_dn_q",    32'(q1), 32'd9);
        check("oor_dn_wrap", 32'(w1), 32'h0);

        // Mid-count reset at 7, then hold via en=0 and via freeze.
        set(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
        tick();
        set(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        repeat (7) tick();
        check("mid_q7", 32'(q1), 32'd7);
        set(1'b0, 1'b1, 2'b01, 4'hF, 4'hF);
        tick();
        check("mid_rst_q",  32'(q1), 32'd0);
        check("mid_rst_q2", 32'(q2), 32'd3);
        set(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        repeat (3) tick();
        set(1'b1, 1'b0, 2'b01, 4'hF, 4'hF);
        repeat (3) begin
            tick();
            check("hold_en_q",    32'(q1),  32'd3);
            check("hold_en_wrap", 32'(w1),  32'h0);
            check("hold_en_tc",   32'(tc1), 32'h0);
        end
        set(1'b1, 1'b1, 2'b11, 4'hF, 4'hF);
        repeat (3) begin
            tick();
            check("frz_q",    32'(q1),  32'd3);
            check("frz_wrap", 32'(w1),  32'h0);
            check("frz_tc",   32'(tc1), 32'h0);
        end

        // tc must stay low at q=9 when disabled or frozen.
        set(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        repeat (6) tick();
        check("tc_at9", 32'(tc1), 32'h1);
        set(1'b1, 1'b0, 2'b01, 4'h0, 4'h0);
        check("tc_en0", 32'(tc1), 32'h0);
        set(1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        check("tc_frz", 32'(tc1), 32'h0);

        // Randomised mix, checked by the model every cycle.
        for (int i = 0; i < 200; i++) begin
            set(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
            tick();
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
